// File: rtl/addsub_pkg.sv
// Shared constants and types for the addsub_pipe pipelined adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
        logic sat;
    } flags_t;

    function automatic int calc_nstg(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple adder, one per pipeline stage of addsub_pipe.
// Also exports the carry into its MSB so overflow can be cross-checked locally.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    always_comb begin : ripple
        logic c;
        // NOTE: blocking assignments are right here: c is a combinational temporary
        // that must carry each bit's result into the next loop iteration.
        c    = cin;
        cmsb = cin;
        s    = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                cmsb = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit two's-complement adder/subtractor, CHUNK bits resolved per stage.
// Define ADDSUB_PIPE_SATURATE_EN to clamp overflowing results to the signed range.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             sat
);

    localparam int NSTG = calc_nstg(WIDTH, CHUNK);
    localparam int LAST = NSTG - 1;

    typedef struct packed {
        logic             v;
        logic             c;   // carry into this stage's chunk
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;   // b already inverted for subtract
        logic [WIDTH-1:0] r;   // result chunks resolved so far
    } stage_t;

    stage_t           st_in [NSTG];
    stage_t           st_d  [NSTG];
    stage_t           st_q  [NSTG];
    logic [CHUNK-1:0] s_w   [NSTG];
    logic             co_w  [NSTG];
    logic             cm_w  [NSTG];

    logic             adv;
    logic [WIDTH-1:0] d_raw;
    logic [WIDTH-1:0] d_fin;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_d;
    logic             sat_d;
    flags_t           flags_d;
    flags_t           flags_q;

    // The whole pipeline moves as one; a stall at the output freezes every stage.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_comb begin
        st_in[0].v = in_valid;
        st_in[0].c = (m == MODE_SUB);
        st_in[0].a = a;
        st_in[0].b = b ^ {WIDTH{m}};
        st_in[0].r = '0;
        for (int k = 1; k < NSTG; k++) begin
            st_in[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (st_in[k].a[k*CHUNK +: CHUNK]),
            .b    (st_in[k].b[k*CHUNK +: CHUNK]),
            .cin  (st_in[k].c),
            .s    (s_w[k]),
            .cout (co_w[k]),
            .cmsb (cm_w[k])
        );
    end

    always_comb begin
        // NOTE: every element gets a full default before the chunk overlay, so no
        // path leaves a bit unassigned and no latch is inferred.
        for (int k = 0; k < NSTG; k++) begin
            st_d[k]                     = st_in[k];
            st_d[k].c                   = co_w[k];
            st_d[k].r[k*CHUNK +: CHUNK] = s_w[k];
        end

        d_raw = st_d[LAST].r;
        a_msb = st_in[LAST].a[WIDTH-1];
        b_msb = st_in[LAST].b[WIDTH-1];
        ovf_d = (a_msb == b_msb) & (d_raw[WIDTH-1] != a_msb);

`ifdef ADDSUB_PIPE_SATURATE_EN
        sat_d = ovf_d;
        if (ovf_d) begin
            d_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            d_fin = d_raw;
        end
`else
        sat_d = 1'b0;
        d_fin = d_raw;
`endif

        st_d[LAST].r = d_fin;
        flags_d = '{cout: co_w[LAST],
                    ovf:  ovf_d,
                    zero: (d_fin == '0),
                    neg:  d_fin[WIDTH-1],
                    sat:  sat_d};
    end

    // NOTE: the data fields are reset as well as the valid bits, so bubble contents
    // and the output word are deterministic from the first cycle out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                st_q[k] <= '0;
            end
            flags_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                st_q[k] <= st_d[k];
            end
            flags_q <= flags_d;
        end
    end

    assign out_valid = st_q[LAST].v;
    assign d         = st_q[LAST].r;
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;
    assign sat       = flags_q.sat;

    // Sign-operand overflow rule must agree with carry-in-to-MSB xor carry-out.
    a_ovf_carry: assert property (@(posedge clk) disable iff (rst)
        ((cm_w[LAST] ^ co_w[LAST]) == ovf_d));

endmodule
